// File: rtl/draw_frame_sequencer.sv
// Frame sequencer: restarts, enables and forwards pixels from each selected drawer
// in index order, then pulses frame_done. One registered VGA write port.
module draw_frame_sequencer #(
    parameter int unsigned N_SRC = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [N_SRC-1:0]      src_mask,
    input  logic [9*N_SRC-1:0]    src_x,
    input  logic [8*N_SRC-1:0]    src_y,
    input  logic [12*N_SRC-1:0]   src_color,
    input  logic [N_SRC-1:0]      src_we,
    input  logic [N_SRC-1:0]      src_done,
    output logic [N_SRC-1:0]      src_enable,
    output logic [N_SRC-1:0]      src_restart,
    output logic [8:0]            vga_x,
    output logic [7:0]            vga_y,
    output logic [11:0]           vga_color,
    output logic                  vga_plot,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_RESTART,
        S_SETTLE,
        S_RUN,
        S_NEXT,
        S_FIN
    } state_t;

    state_t           state, state_next;
    logic [2:0]       idx, idx_next;
    logic [N_SRC-1:0] mask, mask_next;

    logic             sel_mask;
    logic             sel_done;
    logic             sel_we;
    logic [8:0]       sel_x;
    logic [7:0]       sel_y;
    logic [11:0]      sel_color;

    // Source selection by current index; idx never exceeds N_SRC-1.
    always_comb begin
        sel_mask  = 1'b0;
        sel_done  = 1'b0;
        sel_we    = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (idx == 3'(i)) begin
                sel_mask  = mask[i];
                sel_done  = src_done[i];
                sel_we    = src_we[i];
                sel_x     = src_x[9*i +: 9];
                sel_y     = src_y[8*i +: 8];
                sel_color = src_color[12*i +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            mask  <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            mask  <= mask_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        mask_next  = mask;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    mask_next  = src_mask;
                    idx_next   = '0;
                    state_next = S_CHECK;
                end
            end
            S_CHECK:   state_next = sel_mask ? S_RESTART : S_NEXT;
            S_RESTART: state_next = S_SETTLE;
            S_SETTLE:  state_next = S_RUN;
            S_RUN: begin
                if (sel_done) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx == 3'(N_SRC - 1)) begin
                    state_next = S_FIN;
                end else begin
                    idx_next   = idx + 3'd1;
                    state_next = S_CHECK;
                end
            end
            S_FIN:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        src_enable  = '0;
        src_restart = '0;
        busy        = (state != S_IDLE);
        frame_done  = (state == S_FIN);
        for (int unsigned i = 0; i < N_SRC; i++) begin
            src_enable[i]  = (state == S_RUN)     && (idx == 3'(i));
            src_restart[i] = (state == S_RESTART) && (idx == 3'(i));
        end
    end

    // Pixel port: coordinates hold outside RUN, strobe drops to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_x     <= '0;
            vga_y     <= '0;
            vga_color <= '0;
            vga_plot  <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            if (state == S_RUN) begin
                vga_x     <= sel_x;
                vga_y     <= sel_y;
                vga_color <= sel_color;
                vga_plot  <= sel_we;
            end
        end
    end

endmodule

// File: tb/tb_draw_frame_sequencer.sv
// Directed bench for draw_frame_sequencer with four behavioural drawers that
// each emit three pixels and then hold a sticky done until restarted.
module tb_draw_frame_sequencer;

    localparam int unsigned N = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_start;
    logic [N-1:0]    src_mask;
    logic [9*N-1:0]  src_x;
    logic [8*N-1:0]  src_y;
    logic [12*N-1:0] src_color;
    logic [N-1:0]    src_we;
    logic [N-1:0]    src_done;
    logic [N-1:0]    src_enable;
    logic [N-1:0]    src_restart;
    logic [8:0]      vga_x;
    logic [7:0]      vga_y;
    logic [11:0]     vga_color;
    logic            vga_plot;
    logic            busy;
    logic            frame_done;

    always #5 clk = ~clk;

    draw_frame_sequencer #(.N_SRC(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .src_mask    (src_mask),
        .src_x       (src_x),
        .src_y       (src_y),
        .src_color   (src_color),
        .src_we      (src_we),
        .src_done    (src_done),
        .src_enable  (src_enable),
        .src_restart (src_restart),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Behavioural drawers; stuck[i] makes drawer i ignore its restart.
    logic [1:0]   d_cnt [N];
    logic [N-1:0] d_done;
    logic [N-1:0] stuck;
    logic         junk;
    logic         tgl;

    always @(posedge clk) begin
        if (reset) begin
            tgl <= 1'b0;
            for (int i = 0; i < N; i++) begin
                d_cnt[i]  <= 2'd0;
                d_done[i] <= 1'b0;
            end
        end else begin
            tgl <= ~tgl;
            for (int i = 0; i < N; i++) begin
                if (src_restart[i] && !stuck[i]) begin
                    d_cnt[i]  <= 2'd0;
                    d_done[i] <= 1'b0;
                end else if (src_enable[i] && !d_done[i]) begin
                    d_cnt[i] <= d_cnt[i] + 2'd1;
                    if (d_cnt[i] == 2'd2) d_done[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        src_x     = '0;
        src_y     = '0;
        src_color = '0;
        src_we    = '0;
        for (int i = 0; i < N; i++) begin
            src_x[9*i +: 9]      = 9'(i * 100) + 9'(d_cnt[i]);
            src_y[8*i +: 8]      = 8'(i * 16) + 8'(d_cnt[i]);
            src_color[12*i +: 12] = 12'(i * 256) + 12'(d_cnt[i]);
            src_we[i] = (src_enable[i] && !d_done[i]) || (junk && (i % 2 == 1) && tgl);
        end
    end
    assign src_done = d_done;

    // Frame monitor, sampled on the falling edge.
    logic         mon_on;
    int           n_busy;
    int           n_done;
    logic [N-1:0] enable_seen;
    int           rst_q [$];
    logic [28:0]  pix_q [$];

    always @(negedge clk) begin
        if (mon_on) begin
            if (busy) n_busy <= n_busy + 1;
            if (frame_done) n_done <= n_done + 1;
            enable_seen <= enable_seen | src_enable;
            for (int i = 0; i < N; i++)
                if (src_restart[i]) rst_q.push_back(i);
            if (vga_plot) pix_q.push_back({vga_x, vga_y, vga_color});
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear_mon();
        n_busy      = 0;
        n_done      = 0;
        enable_seen = '0;
        rst_q.delete();
        pix_q.delete();
    endtask

    task automatic wait_done(input string tag);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (frame_done) begin
                got = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
        mon_on = 1'b0;
    endtask

    task automatic check_frame(input string tag, input logic [N-1:0] m,
                               input logic [N-1:0] stk, input int exp_busy);
        int          exp_rst [$];
        logic [28:0] exp_pix [$];
        for (int i = 0; i < N; i++) begin
            if (m[i]) begin
                exp_rst.push_back(i);
                if (!stk[i])
                    for (int c = 0; c < 3; c++)
                        exp_pix.push_back({9'(i * 100 + c), 8'(i * 16 + c), 12'(i * 256 + c)});
            end
        end
        check({tag, "_frame_done_count"}, 32'(n_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_busy));
        check({tag, "_enable_seen"}, 32'(enable_seen), 32'(m));
        check({tag, "_restart_count"}, 32'(rst_q.size()), 32'(exp_rst.size()));
        for (int k = 0; k < exp_rst.size() && k < rst_q.size(); k++)
            check($sformatf("%s_restart_order%0d", tag, k), 32'(rst_q[k]), 32'(exp_rst[k]));
        check({tag, "_plot_count"}, 32'(pix_q.size()), 32'(exp_pix.size()));
        for (int k = 0; k < exp_pix.size() && k < pix_q.size(); k++)
            check($sformatf("%s_pixel%0d", tag, k), 32'(pix_q[k]), 32'(exp_pix[k]));
    endtask

    task automatic run_frame(input string tag, input logic [N-1:0] m,
                             input logic [N-1:0] stk, input int exp_busy);
        @(posedge clk);
        #1;
        clear_mon();
        mon_on      = 1'b1;
        src_mask    = m;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        src_mask    = N'($urandom);
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        wait_done(tag);
        check_frame(tag, m, stk, exp_busy);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check({tag, "_enable"}, 32'(src_enable), 32'd0);
        check({tag, "_restart"}, 32'(src_restart), 32'd0);
        check({tag, "_plot"}, 32'(vga_plot), 32'd0);
        check({tag, "_pixel"}, 32'({vga_x, vga_y, vga_color}), 32'd0);
    endtask

    initial begin
        logic found;
        reset       = 1'b1;
        frame_start = 1'b0;
        src_mask    = '0;
        stuck       = '0;
        junk        = 1'b0;
        mon_on      = 1'b0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Full mask: 4 sources x (4 overhead + 4 RUN) + FIN = 33 busy cycles.
        run_frame("all", 4'b1111, 4'b0000, 33);
        // Dones still sticky from the previous frame; restart must clear them.
        run_frame("sticky", 4'b1111, 4'b0000, 33);
        // Two included (8 each) + two skipped (2 each) + FIN = 21.
        junk = 1'b1;
        run_frame("m0101", 4'b0101, 4'b0000, 21);
        junk = 1'b0;
        // Eight CHECK/NEXT cycles + FIN = 9.
        run_frame("m0000", 4'b0000, 4'b0000, 9);
        // Drawer 1 keeps done high: its RUN lasts one cycle, no pixels.
        stuck = 4'b0010;
        run_frame("stuck", 4'b1111, 4'b0010, 30);
        stuck = 4'b0000;

        // frame_start held high through a whole frame, FIN and the next IDLE.
        @(posedge clk);
        #1;
        clear_mon();
        mon_on      = 1'b1;
        src_mask    = 4'b1111;
        frame_start = 1'b1;
        wait_done("hold");
        check("hold_fin_request_ignored", 32'(busy), 32'd0);
        check_frame("hold", 4'b1111, 4'b0000, 33);
        clear_mon();
        mon_on = 1'b1;
        @(posedge clk);
        #1;
        check("hold_idle_request_accepted", 32'(busy), 32'd1);
        frame_start = 1'b0;
        wait_done("hold2");
        check_frame("hold2", 4'b1111, 4'b0000, 33);

        // Reset in the middle of source 2's RUN.
        @(posedge clk);
        #1;
        src_mask    = 4'b1111;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (src_enable == 4'b0100) begin
                found = 1'b1;
                break;
            end
        end
        check("midrun_src2_reached", 32'(found), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all_zero("midrun_reset");
        reset = 1'b0;
        run_frame("after_reset", 4'b1111, 4'b0000, 33);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/draw_frame_sequencer.md
# draw_frame_sequencer

Sits downstream of the per-object drawers (background, gold/stone, hook, score, next-level icon) and upstream of the VGA adapter. On each frame request it runs the enabled drawers one at a time in fixed index order. For each drawer it clears the drawer's sticky done, enables it, and forwards its pixel stream to a single registered VGA write port. It signals frame completion when the last selected drawer finishes.

## Interface
Parameters:
- N_SRC, 4: number of drawer sources (1..8). Index 0 is drawn first; higher indices overdraw lower ones.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle request to draw a frame; ignored while busy=1.
- src_mask  in  N_SRC  per-source include bits; sampled on the accepted frame_start cycle.
- src_x  in  9*N_SRC  packed drawer X outputs; source i uses bits [9i+8:9i].
- src_y  in  8*N_SRC  packed drawer Y outputs; slice [8i+7:8i].
- src_color  in  12*N_SRC  packed drawer colors; slice [12i+11:12i].
- src_we  in  N_SRC  drawer write enables.
- src_done  in  N_SRC  drawer done levels; these are sticky until the drawer is restarted.
- src_enable  out  N_SRC  drawer enable; one-hot or zero.
- src_restart  out  N_SRC  one-cycle pulse that returns a drawer from its done state to its load state (drives the drawer's level_up-style input).
- vga_x  out  9  registered pixel X.
- vga_y  out  8  registered pixel Y.
- vga_color  out  12  registered pixel color.
- vga_plot  out  1  registered write strobe.
- busy  out  1  high from the accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse at end of frame.

## Operation
- State register, current index idx (3 bits), and latched mask.
- States:
  - IDLE: busy=0. On frame_start, latch src_mask, set idx=0, and go to CHECK.
  - CHECK: if mask[idx]=1, go to RESTART. Otherwise go to NEXT.
  - RESTART: src_restart[idx]=1 for exactly this cycle. Go to SETTLE.
  - SETTLE: no outputs asserted. This cycle gives the drawer one edge to leave its done state. Go to RUN.
  - RUN: src_enable[idx]=1, held. The pixel mux is active. When src_done[idx]=1 is sampled, go to NEXT.
  - NEXT: if idx=N_SRC-1, go to FIN. Otherwise idx <= idx+1 and go to CHECK.
  - FIN: frame_done=1 for one cycle. Go to IDLE.
- src_done[idx] is ignored in every state except RUN. src_done of non-selected sources is ignored always.
- Pixel mux:
  - In RUN, the next register values are src_x/src_y/src_color slice [idx], and vga_plot = src_we[idx].
  - In any other state, vga_plot is registered 0 and the last vga_x/vga_y/vga_color values are held.
- A mask of all zeros steps through CHECK/NEXT for every index, then FIN. frame_done still pulses.
- src_enable, src_restart, busy and frame_done are Moore outputs decoded from state and idx.

## Timing
- Reset: all outputs are 0, state is IDLE, idx=0, mask=0. Reset has priority over everything, including mid-frame. The drawers must be reset by the same reset.
- Accepted frame_start on cycle t: busy=1 from t+1.
- Included source i:
  - RESTART lasts 1 cycle.
  - SETTLE lasts 1 cycle.
  - RUN lasts until done is seen.
  - NEXT lasts 1 cycle.
  - Fixed overhead is 4 cycles per included source.
- Skipped source: 2 cycles (CHECK + NEXT).
- Pixel latency: a source pixel presented in cycle t appears on vga_* in cycle t+1. No pixels are dropped while in RUN.
- frame_start during busy: ignored and not queued.
- frame_start in the FIN cycle: ignored.
- frame_start in the first IDLE cycle after FIN: accepted.
- src_done already high on entry to RUN (drawer failed to restart): RUN exits after 1 cycle. This is legal. No pixels are forwarded in that case.

## Test plan
- Reset mid-RUN of source 2 (N_SRC=4):
  - Next cycle: all outputs 0, state IDLE.
  - A subsequent frame_start restarts from index 0.
- Mask 4'b1111, behavioural drawers that each emit 3 pixels then hold done high:
  - Restart pulses appear in order 0,1,2,3.
  - vga_plot shows 12 strobes, with coordinates equal to the source values delayed 1 cycle.
  - frame_done pulses once. busy is high for exactly the expected cycle count.
- Mask 4'b0101:
  - Only sources 0 and 2 get restart/enable.
  - Sources 1 and 3 take 2 cycles each.
  - Pixels from 1/3 never reach vga_plot even if their src_we toggles.
- Mask 0:
  - frame_done arrives 8 cycles after the CHECK entry, plus the FIN cycle.
  - src_enable stays 0 throughout.
- Second frame with sticky done left high from the first frame:
  - The restart pulse clears it, and each drawer redraws fully (3 pixels each).
- frame_start asserted every cycle during a frame:
  - Exactly one frame is drawn.
  - A new frame starts only on an IDLE-cycle request.
